// File: rtl/lifo_stack.sv
// lifo_stack: parameterised last-in-first-out stack with valid/ready push and
// pop ports. Storage is a register array addressed by one stack pointer (sp),
// which also equals the number of stored entries. The top of stack is
// mem[sp-1]. It is decoded from registered state and presented on the pop port.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset (empties the stack)
//   flush_i       synchronous clear, overrides push and pop
//   push_valid_i  producer offers push_data_i
//   push_data_i   word to push
//   push_ready_o  stack can accept a word (not full)
//   pop_valid_o   pop_data_o holds the top-of-stack word (not empty)
//   pop_data_o    top-of-stack word, zero when empty
//   pop_ready_i   consumer takes the top word
//   count_o       number of stored entries
//   full_o        count_o == DEPTHSTACK
//   empty_o       count_o == 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on valid. All outputs depend only on
// registered state. A producer holds valid and data stable until its push
// fires. pop_data_o stays stable while pop_valid_o is high and nothing fires.

module lifo_stack #(
  parameter int SIZEDATA   = 32,
  parameter int DEPTHSTACK = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              push_valid_i,
  input  logic [SIZEDATA-1:0]               push_data_i,
  output logic                              push_ready_o,
  output logic                              pop_valid_o,
  output logic [SIZEDATA-1:0]               pop_data_o,
  input  logic                              pop_ready_i,
  output logic [$clog2(DEPTHSTACK+1)-1:0]   count_o,
  output logic                              full_o,
  output logic                              empty_o
);

  localparam int CW = $clog2(DEPTHSTACK + 1);
  // Address width of the storage array. sp itself needs one more value
  // (DEPTHSTACK) than any address, so addresses are truncated copies of it.
  localparam int AW = (DEPTHSTACK > 1) ? $clog2(DEPTHSTACK) : 1;

  logic [SIZEDATA-1:0] mem [DEPTHSTACK];
  logic [CW-1:0]       sp;
  logic [CW-1:0]       top_ptr;
  logic [AW-1:0]       top_addr;
  logic [AW-1:0]       wr_addr;
  logic                full;
  logic                empty;
  logic                push_fire;
  logic                pop_fire;
  logic                clear;

  assign full     = (sp == CW'(DEPTHSTACK));
  assign empty    = (sp == '0);
  assign top_ptr  = sp - CW'(1);
  // The truncation is only used when the value fits. top_addr is read only
  // when the stack is non-empty. wr_addr is written only when the stack is
  // not full.
  assign top_addr = top_ptr[AW-1:0];
  assign wr_addr  = sp[AW-1:0];

  assign clear     = rst_i || flush_i;
  assign push_fire = push_valid_i && !full;
  assign pop_fire  = pop_ready_i && !empty;

  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign pop_data_o   = empty ? '0 : mem[top_addr];
  assign count_o      = sp;
  assign full_o       = full;
  assign empty_o      = empty;

  // Stack pointer: reset and flush win. A simultaneous push and pop replaces
  // the top entry, so the depth does not change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp <= '0;
    end else if (flush_i) begin
      sp <= '0;
    end else if (push_fire && !pop_fire) begin
      sp <= sp + CW'(1);
    end else if (pop_fire && !push_fire) begin
      sp <= sp - CW'(1);
    end
  end

  // Storage has no reset. A pop leaves the old word in place. It is
  // unreachable until it is overwritten.
  always_ff @(posedge clk_i) begin
    if (!clear) begin
      if (push_fire && pop_fire) begin
        mem[top_addr] <= push_data_i;
      end else if (push_fire) begin
        mem[wr_addr] <= push_data_i;
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int W     = 32;
  localparam int DEP_A = 8;
  localparam int DEP_B = 5;

  // Instance A: DEPTHSTACK=8, used for the directed scenarios.
  logic         a_rst, a_flush, a_push_valid, a_push_ready, a_pop_valid, a_pop_ready;
  logic         a_full, a_empty;
  logic [W-1:0] a_push_data, a_pop_data;
  logic [3:0]   a_count;

  // Instance B: DEPTHSTACK=5 (not a power of 2), used for random stress.
  logic         b_rst, b_flush, b_push_valid, b_push_ready, b_pop_valid, b_pop_ready;
  logic         b_full, b_empty;
  logic [W-1:0] b_push_data, b_pop_data;
  logic [2:0]   b_count;

  lifo_stack #(.SIZEDATA(W), .DEPTHSTACK(DEP_A)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
    .push_valid_i(a_push_valid), .push_data_i(a_push_data), .push_ready_o(a_push_ready),
    .pop_valid_o(a_pop_valid), .pop_data_o(a_pop_data), .pop_ready_i(a_pop_ready),
    .count_o(a_count), .full_o(a_full), .empty_o(a_empty)
  );

  lifo_stack #(.SIZEDATA(W), .DEPTHSTACK(DEP_B)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
    .push_valid_i(b_push_valid), .push_data_i(b_push_data), .push_ready_o(b_push_ready),
    .pop_valid_o(b_pop_valid), .pop_data_o(b_pop_data), .pop_ready_i(b_pop_ready),
    .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // One clock cycle on instance A. Inputs are applied at the falling edge.
  // The pre-edge outputs are captured. Inputs return to idle just after the
  // rising edge, so consecutive calls occupy consecutive cycles.
  logic         s_push_ready, s_pop_valid;
  logic [W-1:0] s_pop_data;

  task automatic a_step(input logic pv, input logic [W-1:0] pd, input logic pr,
                        input logic fl, input logic rs);
    @(negedge clk);
    a_push_valid = pv; a_push_data = pd; a_pop_ready = pr; a_flush = fl; a_rst = rs;
    #1;
    s_push_ready = a_push_ready;
    s_pop_valid  = a_pop_valid;
    s_pop_data   = a_pop_data;
    @(posedge clk);
    #1;
    a_push_valid = 1'b0; a_pop_ready = 1'b0; a_flush = 1'b0; a_rst = 1'b0;
  endtask

  task automatic a_push(input logic [W-1:0] d);
    a_step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic a_pop_expect(input string tag, input logic [W-1:0] exp);
    a_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check({tag, "_valid"}, W'(s_pop_valid), 32'd1);
    check(tag, s_pop_data, exp);
  endtask

  task automatic a_state(input string tag, input int cnt, input logic [W-1:0] top);
    check({tag, "_count"}, W'(a_count), W'(cnt));
    check({tag, "_top"},   a_pop_data, top);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] model[$];  // reference stack, back = top
  logic [W-1:0] exp_q[$];  // words the consumer is owed, in order

  // ---------------------------------------------------------------- stimulus
  logic         r_pv, r_pr, r_fl, r_rs, r_hold, r_push_fire, r_pop_fire;
  logic [W-1:0] r_pd, r_top;

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_push_valid = 1'b0; a_push_data = '0; a_pop_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_push_valid = 1'b0; b_push_data = '0; b_pop_ready = 1'b0;

    // Reset values
    a_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_count", W'(a_count), 32'd0);
    check("rst_push_ready", W'(a_push_ready), 32'd1);
    check("rst_pop_valid", W'(a_pop_valid), 32'd0);
    check("rst_pop_data", a_pop_data, 32'd0);
    check("rst_full", W'(a_full), 32'd0);
    check("rst_empty", W'(a_empty), 32'd1);

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) a_push(W'(i * 'h11));
    check("fill_full", W'(a_full), 32'd1);
    check("fill_push_ready", W'(a_push_ready), 32'd0);
    a_state("fill", 8, 32'h88);

    // A ninth push is refused
    a_step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    check("ninth_ready", W'(s_push_ready), 32'd0);
    a_state("ninth", 8, 32'h88);

    // Drain in reverse order
    for (int i = 8; i >= 1; i--) a_pop_expect("drain", W'(i * 'h11));
    check("drain_empty", W'(a_empty), 32'd1);
    check("drain_pop_valid", W'(a_pop_valid), 32'd0);
    check("drain_pop_data", a_pop_data, 32'd0);

    // Replace-top: push and pop in the same cycle
    a_push(32'hA); a_push(32'hB); a_push(32'hC);
    a_step(1'b1, 32'hD, 1'b1, 1'b0, 1'b0);
    check("swap_popped", s_pop_data, 32'hC);
    a_state("swap", 3, 32'hD);
    a_pop_expect("swap_pop1", 32'hD);
    a_pop_expect("swap_pop2", 32'hB);
    a_pop_expect("swap_pop3", 32'hA);

    // Push and pop together while empty: only the push fires
    a_step(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
    check("empty_both_popv", W'(s_pop_valid), 32'd0);
    a_state("empty_both", 1, 32'h5);
    a_pop_expect("empty_both_pop", 32'h5);

    // Push and pop together while full: only the pop fires
    for (int i = 1; i <= 8; i++) a_push(W'(i));
    a_step(1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
    check("full_both_popped", s_pop_data, 32'd8);
    a_state("full_both", 7, 32'd7);

    // Flush alongside a push
    a_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) a_push(W'(i + 'h40));
    a_state("pre_flush", 5, 32'h45);
    a_step(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    check("flush_count", W'(a_count), 32'd0);
    check("flush_empty", W'(a_empty), 32'd1);
    a_push(32'h55);
    a_state("post_flush", 1, 32'h55);

    // Same sequence using reset
    a_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) a_push(W'(i + 'h60));
    a_step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
    check("mrst_count", W'(a_count), 32'd0);
    check("mrst_empty", W'(a_empty), 32'd1);
    a_push(32'h55);
    a_state("post_mrst", 1, 32'h55);

    // Random stress on the depth-5 instance
    @(negedge clk); b_rst = 1'b1;
    @(negedge clk); b_rst = 1'b0;
    model.delete();
    r_hold = 1'b0; r_pv = 1'b0; r_pd = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      r_top = (model.size() > 0) ? model[$] : '0;
      check("st_count", W'(b_count), W'(model.size()));
      check("st_full", W'(b_full), W'(model.size() == DEP_B));
      check("st_empty", W'(b_empty), W'(model.size() == 0));
      check("st_push_ready", W'(b_push_ready), W'(model.size() < DEP_B));
      check("st_top", b_pop_data, r_top);

      // A refused push keeps its word offered.
      if (!r_hold) begin
        r_pv = ($urandom_range(0, 3) != 0);
        r_pd = $urandom;
      end
      r_pr = ($urandom_range(0, 2) != 0);
      r_fl = ($urandom_range(0, 99) == 0);
      r_rs = ($urandom_range(0, 199) == 0);
      b_push_valid = r_pv; b_push_data = r_pd; b_pop_ready = r_pr;
      b_flush = r_fl; b_rst = r_rs;

      r_push_fire = r_pv && (model.size() < DEP_B);
      r_pop_fire  = r_pr && (model.size() > 0);
      if (r_rs || r_fl) begin
        model.delete();
      end else begin
        if (r_pop_fire) begin
          exp_q.push_back(model[$]);
          check("st_popped", b_pop_data, exp_q.pop_front());
        end
        if (r_push_fire && r_pop_fire) model[$] = r_pd;
        else if (r_push_fire) model.push_back(r_pd);
        else if (r_pop_fire) void'(model.pop_back());
      end
      r_hold = r_pv && !r_push_fire && !(r_rs || r_fl);
      @(posedge clk);
    end
    @(negedge clk);
    b_push_valid = 1'b0; b_pop_ready = 1'b0; b_flush = 1'b0; b_rst = 1'b0;
    check("st_final_count", W'(b_count), W'(model.size()));

    // ---------------------------------------------------------------- report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
